// File: rtl/branch_exec_unit.sv
// Branch/jump execution unit: resolves one op per push cycle and queues the
// result in a small FIFO that drains to the CDB arbiter over valid/ready.
module branch_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                       clk_in,
    input  logic                       rstn_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [XLEN-1:0]            in_rs1,
    input  logic [XLEN-1:0]            in_rs2,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_pred_taken,
    input  logic [XLEN-1:0]            in_pred_target,
    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic                       cdb_taken,
    output logic [XLEN-1:0]            cdb_target,
    output logic [XLEN-1:0]            cdb_data,
    output logic                       cdb_mispredict,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_BEQ  = 4'd0;
    localparam logic [3:0] OP_BNE  = 4'd1;
    localparam logic [3:0] OP_BLT  = 4'd4;
    localparam logic [3:0] OP_BGE  = 4'd5;
    localparam logic [3:0] OP_BLTU = 4'd6;
    localparam logic [3:0] OP_BGEU = 4'd7;
    localparam logic [3:0] OP_JAL  = 4'd8;
    localparam logic [3:0] OP_JALR = 4'd9;

    logic [TAG_W-1:0] tag_mem    [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [XLEN-1:0]  target_mem [DEPTH];
    logic [XLEN-1:0]  data_mem   [DEPTH];
    logic             mis_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty;
    logic push, push_en, pop;

    // Resolution datapath
    logic            legal;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_data;
    logic            res_mis;
    logic            eq, lt, ltu;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] pc_plus_step;
    logic [XLEN-1:0] rs1_plus_imm;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign cdb_valid = !empty;
    assign pop       = cdb_valid & cdb_ready & rdy_in & !flush_in;
    assign in_ready  = rdy_in & (!full | pop);
    assign push      = in_valid & in_ready & !flush_in;
    assign push_en   = push & legal;

    assign eq           = (in_rs1 == in_rs2);
    assign lt           = ($signed(in_rs1) < $signed(in_rs2));
    assign ltu          = (in_rs1 < in_rs2);
    assign pc_plus_imm  = in_pc + in_imm;
    assign pc_plus_step = in_pc + XLEN'(PC_STEP);
    assign rs1_plus_imm = in_rs1 + in_imm;

    always_comb begin
        legal      = 1'b1;
        res_taken  = 1'b0;
        res_target = pc_plus_step;
        res_data   = '0;
        unique case (in_op)
            OP_BEQ:  res_taken = eq;
            OP_BNE:  res_taken = !eq;
            OP_BLT:  res_taken = lt;
            OP_BGE:  res_taken = !lt;
            OP_BLTU: res_taken = ltu;
            OP_BGEU: res_taken = !ltu;
            OP_JAL: begin
                res_taken = 1'b1;
                res_data  = pc_plus_step;
            end
            OP_JALR: begin
                res_taken = 1'b1;
                res_data  = pc_plus_step;
            end
            default: legal = 1'b0;
        endcase
        if (in_op == OP_JALR) begin
            res_target = {rs1_plus_imm[XLEN-1:1], 1'b0};
        end else if (res_taken) begin
            res_target = pc_plus_imm;
        end
        res_mis = (res_taken != in_pred_taken) | (res_target != in_pred_target);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (rdy_in) begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (push_en) begin
            tag_mem[wr_ptr_q]    <= in_tag;
            taken_mem[wr_ptr_q]  <= res_taken;
            target_mem[wr_ptr_q] <= res_target;
            data_mem[wr_ptr_q]   <= res_data;
            mis_mem[wr_ptr_q]    <= res_mis;
        end
    end

    always_comb begin
        cdb_tag        = '0;
        cdb_taken      = 1'b0;
        cdb_target     = '0;
        cdb_data       = '0;
        cdb_mispredict = 1'b0;
        if (cdb_valid) begin
            cdb_tag        = tag_mem[rd_ptr_q];
            cdb_taken      = taken_mem[rd_ptr_q];
            cdb_target     = target_mem[rd_ptr_q];
            cdb_data       = data_mem[rd_ptr_q];
            cdb_mispredict = mis_mem[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: doc/branch_exec_unit.md
Name: branch_exec_unit

Overview:
- Parametrised, buffered branch/jump execution unit. Sits between the branch reservation station and the CDB arbiter.
- Each accepted op is resolved in one registered stage: condition, target, link value and misprediction flag.
- Results are queued in an output FIFO. The FIFO drains through a valid/ready handshake with the CDB arbiter.
- A flush input clears all in-flight results.

Parameters:
XLEN, 32, data and address width
TAG_W, 4, ROB tag width
DEPTH, 4, result FIFO entries (power of two, >=2)
PC_STEP, 4, not-taken / link increment

Ports:
clk_in  input  1  clock
rstn_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; when 0 no state changes
flush_in  input  1  clear FIFO (misprediction recovery)
in_valid  input  1  op offered by RS
in_ready  output  1  unit can accept op this cycle
in_op  input  4  0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 8 JAL, 9 JALR; others illegal
in_rs1  input  XLEN  operand 1
in_rs2  input  XLEN  operand 2
in_imm  input  XLEN  sign-extended immediate
in_pc  input  XLEN  instruction pc
in_tag  input  TAG_W  destination ROB tag
in_pred_taken  input  1  fetch-stage prediction
in_pred_target  input  XLEN  fetch-stage predicted next pc
cdb_valid  output  1  FIFO head valid
cdb_ready  input  1  arbiter grant
cdb_tag  output  TAG_W  head tag
cdb_taken  output  1  resolved direction
cdb_target  output  XLEN  resolved next pc
cdb_data  output  XLEN  link value (pc+PC_STEP for JAL/JALR, else 0)
cdb_mispredict  output  1  head needs redirect
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rstn_in=0, asynchronous):
  - FIFO is emptied and count=0.
  - cdb_valid=0; cdb_tag, cdb_taken, cdb_target, cdb_data and cdb_mispredict are all 0.
  - in_ready=1.
- Push and pop events:
  - Push: in_valid & in_ready & rdy_in & !flush_in.
  - Pop: cdb_valid & cdb_ready & rdy_in & !flush_in.
- Handshake:
  - in_ready = !full | pop. It is combinational from cdb_ready and may fall in the same cycle.
  - in_ready=0 while rdy_in=0.
  - cdb_* outputs are held stable until popped.
- Resolution is computed on the push cycle and written into the FIFO tail.
  - Latency: the result appears at cdb_* on the cycle after push when the FIFO was empty (or becoming empty). No combinational input-to-CDB path.
  - Conditional branches: taken per op. Signed compare for BLT/BGE, unsigned for BLTU/BGEU.
    - target = taken ? pc+imm : pc+PC_STEP.
    - data = 0.
  - JAL: taken=1, target = pc+imm, data = pc+PC_STEP.
  - JALR: taken=1, target = (rs1+imm) & ~1, data = pc+PC_STEP.
  - All adds are modulo 2^XLEN with wrap-around and no overflow flag.
  - mispredict = (taken != pred_taken) | (target != pred_target).
- Illegal op: accepted (consumes handshake) but not enqueued; count unchanged.
- Simultaneous events:
  - Push and pop when full: allowed; count stays DEPTH.
  - Push and pop when empty: the new entry appears at the head the next cycle; no bypass.
- Flush:
  - Synchronous. Next cycle count=0 and cdb_valid=0.
  - Any push in the flush cycle is discarded; no pop occurs.
  - Flush wins over all other events.
- rdy_in=0: pointers, count and contents are frozen; cdb_* outputs still display the head.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count.

Test Plan:
- Reset then idle:
  - Stimulus: rstn_in low mid-run with 3 entries queued.
  - Required: count=0, cdb_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- BEQ taken:
  - Stimulus: pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=0, pred_target=0x104, cdb_ready=1.
  - Required: next cycle cdb_taken=1, target=0x120, data=0, mispredict=1.
- JALR:
  - Stimulus: rs1=0x1001, imm=0x10, pc=0x200, pred_taken=1, pred_target=0x1010.
  - Required: target=0x1010, data=0x204, mispredict=0.
- Signed compare and wrap:
  - BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1.
  - BLTU with the same operands -> taken=0, target = pc+4.
  - pc=0xFFFFFFFC with imm=8 -> target=0x4.
- Backpressure:
  - Stimulus: cdb_ready=0 while pushing DEPTH ops.
  - Required:
    - count=4 and in_ready drops.
    - Raising cdb_ready with in_valid held gives a same-cycle pop and push; count stays 4.
    - Drain order matches tag order.
- Flush and stall:
  - Stimulus: flush_in with 2 entries queued plus in_valid.
  - Required: next cycle count=0, cdb_valid=0, incoming op dropped.
  - Stall: rdy_in=0 for 3 cycles -> no count or output change.
  - Illegal op 0xF -> accepted, count unchanged.
